conga_step_timer: RTL and testbench

//   Parametrised successor to the fixed 16-bit conga step counter.

---
 rtl/conga_step_timer_if.sv | 22 ++
 rtl/conga_step_timer.sv | 79 +++++++
 tb/tb_conga_step_timer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/conga_step_timer_if.sv
// Control/status bundle between the game control FSM (master) and the step timer (slave).
interface conga_step_timer_if #(
  parameter int WIDTH = 16
) ();
  logic             go;
  logic             en;
  logic             hold;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             paused;
  logic             done;

  modport master (
    output go, en, hold,
    input  count, running, paused, done
  );

  modport slave (
    input  go, en, hold,
    output count, running, paused, done
  );
endinterface

// File: rtl/conga_step_timer.sv
// Prescaled step counter from 0 to MAX_COUNT with pause, one-shot/wrap modes and a terminal pulse.
module conga_step_timer #(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 39648,
  parameter int PRESCALE  = 1,
  parameter int WRAP      = 0
) (
  input logic             clk,
  input logic             resetn,
  conga_step_timer_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] PRE_MAX  = WIDTH'(MAX_COUNT - 1);
  localparam logic [PW-1:0]    PS_LAST  = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [PW-1:0]    prescaler;
  logic [WIDTH-1:0] count_q;
  logic             done_q;

  // go restarts from any state; otherwise hold beats en, and only RUN can step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      prescaler <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.go) begin
        state     <= RUN;
        prescaler <= '0;
        count_q   <= '0;
      end else begin
        case (state)
          IDLE: count_q <= '0;
          RUN: begin
            if (bus.hold) begin
              state <= HOLD;
            end else if (bus.en) begin
              if (prescaler != PS_LAST) begin
                prescaler <= prescaler + PW'(1);
              end else begin
                prescaler <= '0;
                if (count_q == MAX_C) begin
                  count_q <= '0;
                end else if (count_q == PRE_MAX) begin
                  count_q <= MAX_C;
                  done_q  <= 1'b1;
                  if (WRAP == 0) state <= DONE;
                end else begin
                  count_q <= count_q + WIDTH'(1);
                end
              end
            end
          end
          HOLD: if (!bus.hold) state <= RUN;
          DONE: count_q <= MAX_C;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state == RUN);
  assign bus.paused  = (state == HOLD);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_conga_step_timer.sv
// Directed bench: one-shot, wrap and prescaled instances driven from a single linear sequence.
module tb_conga_step_timer;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  conga_step_timer_if #(.WIDTH(4)) if_a ();
  conga_step_timer_if #(.WIDTH(4)) if_b ();
  conga_step_timer_if #(.WIDTH(4)) if_c ();

  conga_step_timer #(.WIDTH(4), .MAX_COUNT(5), .PRESCALE(1), .WRAP(0)) dut_a (
    .clk(clk), .resetn(resetn), .bus(if_a.slave));
  conga_step_timer #(.WIDTH(4), .MAX_COUNT(5), .PRESCALE(1), .WRAP(1)) dut_b (
    .clk(clk), .resetn(resetn), .bus(if_b.slave));
  conga_step_timer #(.WIDTH(4), .MAX_COUNT(5), .PRESCALE(3), .WRAP(0)) dut_c (
    .clk(clk), .resetn(resetn), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_a(input string tag, input int cnt, input int run, input int pau, input int dn);
    check_output({tag, " a.count"},   int'(if_a.count),   cnt);
    check_output({tag, " a.running"}, int'(if_a.running), run);
    check_output({tag, " a.paused"},  int'(if_a.paused),  pau);
    check_output({tag, " a.done"},    int'(if_a.done),    dn);
  endtask

  task automatic check_c(input string tag, input int cnt, input int run, input int pau, input int dn);
    check_output({tag, " c.count"},   int'(if_c.count),   cnt);
    check_output({tag, " c.running"}, int'(if_c.running), run);
    check_output({tag, " c.paused"},  int'(if_c.paused),  pau);
    check_output({tag, " c.done"},    int'(if_c.done),    dn);
  endtask

  task automatic apply_stimulus(input int inst, input logic go, input logic en, input logic hold);
    case (inst)
      0: begin if_a.go = go; if_a.en = en; if_a.hold = hold; end
      1: begin if_b.go = go; if_b.en = en; if_b.hold = hold; end
      default: begin if_c.go = go; if_c.en = en; if_c.hold = hold; end
    endcase
  endtask

  initial begin
    logic [5:0] en_pat;
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(2, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_a("reset", 0, 0, 0, 0);
    check_output("reset b.count", int'(if_b.count), 0);
    check_c("reset", 0, 0, 0, 0);
    resetn = 1'b1;

    // IDLE ignores en until go
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    tick();
    check_a("idle_en", 0, 0, 0, 0);

    $display("[TB] one-shot count to terminal");
    apply_stimulus(0, 1'b1, 1'b0, 1'b0);
    tick();
    check_a("go_a", 0, 1, 0, 0);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      tick();
      check_a("oneshot", n, (n == 5) ? 0 : 1, 0, (n == 5) ? 1 : 0);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      check_a("done_hold", 5, 0, 0, 0);
    end

    $display("[TB] wrap mode");
    apply_stimulus(1, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("go_b count", int'(if_b.count), 0);
    check_output("go_b running", int'(if_b.running), 1);
    apply_stimulus(1, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 14; n++) begin
      tick();
      check_output("wrap count", int'(if_b.count), n % 6);
      check_output("wrap done", int'(if_b.done), ((n % 6) == 5) ? 1 : 0);
      check_output("wrap running", int'(if_b.running), 1);
    end

    $display("[TB] prescale 3 with gapped en");
    apply_stimulus(2, 1'b1, 1'b0, 1'b0);
    tick();
    check_c("go_c", 0, 1, 0, 0);
    en_pat = 6'b101101;
    for (int n = 0; n < 6; n++) begin
      apply_stimulus(2, 1'b0, en_pat[n], 1'b0);
      tick();
      check_c("presc", (n >= 3) ? 1 : 0, 1, 0, 0);
    end
    apply_stimulus(2, 1'b0, 1'b1, 1'b0);
    tick();
    check_c("presc_p2", 1, 1, 0, 0);
    tick();
    check_c("presc_step2", 2, 1, 0, 0);

    $display("[TB] hold mid-phase");
    tick();
    check_c("pre_hold", 2, 1, 0, 0);
    apply_stimulus(2, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      tick();
      check_c("hold", 2, 0, 1, 0);
    end
    apply_stimulus(2, 1'b0, 1'b1, 1'b0);
    tick();
    check_c("release", 2, 1, 0, 0);
    tick();
    check_c("resume_p2", 2, 1, 0, 0);
    tick();
    check_c("resume_step", 3, 1, 0, 0);

    $display("[TB] go priority");
    apply_stimulus(2, 1'b0, 1'b1, 1'b1);
    tick();
    check_c("hold_again", 3, 0, 1, 0);
    apply_stimulus(2, 1'b1, 1'b1, 1'b1);
    tick();
    check_c("go_in_hold", 0, 1, 0, 0);
    apply_stimulus(2, 1'b0, 1'b0, 1'b0);

    apply_stimulus(0, 1'b1, 1'b1, 1'b1);
    tick();
    check_a("go_in_done", 0, 1, 0, 0);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      check_a("approach", n, 1, 0, 0);
    end
    apply_stimulus(0, 1'b1, 1'b1, 1'b0);
    tick();
    check_a("go_at_terminal", 0, 1, 0, 0);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    tick();
    check_a("after_go_term", 1, 1, 0, 0);
    tick();
    tick();
    check_a("mid_count", 3, 1, 0, 0);

    $display("[TB] async reset mid-count");
    #3;
    resetn = 1'b0;
    #1;
    check_a("async_reset", 0, 0, 0, 0);
    check_c("async_reset", 0, 0, 0, 0);
    check_output("async_reset b.count", int'(if_b.count), 0);
    tick();
    resetn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check_a("idle_after_reset", 0, 0, 0, 0);
    end
    apply_stimulus(0, 1'b1, 1'b1, 1'b0);
    tick();
    check_a("restart", 0, 1, 0, 0);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0);
    tick();
    check_a("restart_step", 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
